// File: rtl/rgb_fade_pkg.sv
// Shared types and constants for the RGB fade sequencer.
// gamma8 is only referenced when RGB_FADE_GAMMA_EN is defined.
package rgb_fade_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned PWM_BITS = 8;

  localparam int unsigned RED_LSB = 16;
  localparam int unsigned GRN_LSB = 8;
  localparam int unsigned BLU_LSB = 0;

  // Moves one LSB toward the target; never overshoots and never wraps.
  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
    if (cur < tgt)      return cur + 1'b1;
    else if (cur > tgt) return cur - 1'b1;
    else                return cur;
  endfunction

  function automatic logic [PWM_BITS-1:0] gamma8(input logic [PWM_BITS-1:0] lvl);
    logic [2*PWM_BITS-1:0] sq;
    sq = lvl * lvl;
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction

endpackage

// File: rtl/rgb_pwm3.sv
// Three-channel PWM: one shared free-running counter, three registered
// comparators. A pin is high while the counter is below its drive value.
module rgb_pwm3
  import rgb_fade_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] drive_red,
  input  logic [PWM_BITS-1:0] drive_green,
  input  logic [PWM_BITS-1:0] drive_blue,
  output logic                pwm_red,
  output logic                pwm_green,
  output logic                pwm_blue
);

  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt   <= '0;
      pwm_red   <= 1'b0;
      pwm_green <= 1'b0;
      pwm_blue  <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + 1'b1;
      pwm_red   <= (pwm_cnt < drive_red);
      pwm_green <= (pwm_cnt < drive_green);
      pwm_blue  <= (pwm_cnt < drive_blue);
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Command-driven RGB fade/hold sequencer driving the LED pins through rgb_pwm3.
// Define RGB_FADE_GAMMA_EN to square-law the PWM drive; level_* stay linear.
module rgb_fade_sequencer
  import rgb_fade_pkg::*;
#(
  parameter int unsigned STEP_DIV_BITS = 12,
  parameter int unsigned HOLD_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [23:0]          cmd_color,
  input  logic [HOLD_BITS-1:0] cmd_hold,
  output logic [7:0]           level_red,
  output logic [7:0]           level_green,
  output logic [7:0]           level_blue,
  output logic                 pwm_red,
  output logic                 pwm_green,
  output logic                 pwm_blue,
  output logic                 busy,
  output logic                 done
);

  state_t                   state;
  logic [STEP_DIV_BITS-1:0] presc;
  logic                     tick;
  logic [2:0][PWM_BITS-1:0] lvl;
  logic [2:0][PWM_BITS-1:0] tgt;
  logic [HOLD_BITS-1:0]     hold_lat;
  logic [HOLD_BITS-1:0]     hold_cnt;
  logic                     accept;
  logic                     at_target;
  logic [PWM_BITS-1:0]      drive_red;
  logic [PWM_BITS-1:0]      drive_green;
  logic [PWM_BITS-1:0]      drive_blue;

  assign tick      = &presc;
  assign cmd_ready = (state == IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign at_target = (lvl == tgt);
  assign busy      = (state != IDLE);

  // Index 2 = red, 1 = green, 0 = blue, matching the colour word order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      lvl      <= '0;
      tgt      <= '0;
      hold_lat <= '0;
      hold_cnt <= '0;
      done     <= 1'b0;
    end else begin
      presc <= presc + 1'b1;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tgt[2]   <= cmd_color[RED_LSB +: PWM_BITS];
            tgt[1]   <= cmd_color[GRN_LSB +: PWM_BITS];
            tgt[0]   <= cmd_color[BLU_LSB +: PWM_BITS];
            hold_lat <= cmd_hold;
            state    <= FADE;
          end
        end
        FADE: begin
          if (at_target) begin
            hold_cnt <= hold_lat;
            state    <= HOLD;
          end else if (tick) begin
            for (int unsigned c = 0; c < 3; c++) begin
              lvl[c] <= step_toward(lvl[c], tgt[c]);
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (tick) begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign level_red   = lvl[2];
  assign level_green = lvl[1];
  assign level_blue  = lvl[0];

`ifdef RGB_FADE_GAMMA_EN
  always_comb begin
    drive_red   = gamma8(lvl[2]);
    drive_green = gamma8(lvl[1]);
    drive_blue  = gamma8(lvl[0]);
  end
`else
  always_comb begin
    drive_red   = lvl[2];
    drive_green = lvl[1];
    drive_blue  = lvl[0];
  end
`endif

  rgb_pwm3 u_pwm (
    .clk         (clk),
    .rst         (rst),
    .drive_red   (drive_red),
    .drive_green (drive_green),
    .drive_blue  (drive_blue),
    .pwm_red     (pwm_red),
    .pwm_green   (pwm_green),
    .pwm_blue    (pwm_blue)
  );

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for rgb_fade_sequencer with a 4-cycle step tick.
// Expected PWM duty switches with RGB_FADE_GAMMA_EN.
module tb_rgb_fade_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [23:0] cmd_color = '0;
  logic [7:0]  cmd_hold = '0;
  logic        cmd_ready;
  logic [7:0]  level_red, level_green, level_blue;
  logic        pwm_red, pwm_green, pwm_blue;
  logic        busy, done;

  rgb_fade_sequencer #(.STEP_DIV_BITS(2), .HOLD_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_color   (cmd_color),
    .cmd_hold    (cmd_hold),
    .level_red   (level_red),
    .level_green (level_green),
    .level_blue  (level_blue),
    .pwm_red     (pwm_red),
    .pwm_green   (pwm_green),
    .pwm_blue    (pwm_blue),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

`ifdef RGB_FADE_GAMMA_EN
  localparam int E1R = 16, E1G = 254, E2R = 64, E2G = 0;
`else
  localparam int E1R = 64, E1G = 255, E2R = 128, E2G = 15;
`endif

  // ticks: step ticks from the cycle after accept through the done cycle (-1 = skip)
  // lat:   cycles from accept to done (0 = skip)
  typedef struct {
    logic [23:0] color;
    int          ticks;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  bit   mon_en = 0;
  logic [1:0] ph;

  // Independent step-tick phase: all-ones one cycle in four, cleared by rst.
  always @(posedge clk) ph <= rst ? 2'd0 : ph + 2'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit ok_step(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = b - a;
    return (d == 8'd0) || (d == 8'd1) || (d == 8'hFF);
  endfunction

  // Monitor: checks stepping rules every cycle and pops the scoreboard on done.
  bit         tracking = 0, prev_rst = 1, prev_tick = 0;
  int         cyc = 0, tk = 0;
  logic [7:0] pr, pg, pb;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      tracking = 0;
      prev_rst = 1;
    end else begin
      if (!prev_rst && ({level_red, level_green, level_blue} != {pr, pg, pb})) begin
        check("step_on_tick", {31'd0, prev_tick}, 32'd1);
        check("step_size", {31'd0, ok_step(pr, level_red) && ok_step(pg, level_green)
                                   && ok_step(pb, level_blue)}, 32'd1);
      end
      if (tracking) begin
        cyc++;
        if (ph == 2'd3) tk++;
      end
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          check("done_unexpected", {31'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("final_color", {8'd0, level_red, level_green, level_blue}, {8'd0, e.color});
          if (e.ticks >= 0) check("ticks_to_done", tk, e.ticks);
          if (e.lat > 0)    check("latency", cyc, e.lat);
        end
        tracking = 0;
      end
      if (cmd_valid && cmd_ready) begin
        tracking = 1;
        cyc = 0;
        tk = 0;
      end
      prev_rst  = 0;
      prev_tick = (ph == 2'd3);
      pr = level_red;
      pg = level_green;
      pb = level_blue;
    end
  end

  task automatic wait_accept(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 5000);
    check(name, {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic send(input logic [23:0] c, input logic [7:0] h, input string name);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_color = c;
    cmd_hold  = h;
    wait_accept(name);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic measure(input int er, input int eg, input int eb);
    int cr = 0, cg = 0, cb = 0;
    repeat (256) begin
      @(negedge clk);
      cr += int'(pwm_red);
      cg += int'(pwm_green);
      cb += int'(pwm_blue);
    end
    check("duty_red", cr, er);
    check("duty_green", cg, eg);
    check("duty_blue", cb, eb);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);
    check("rst_levels", {8'd0, level_red, level_green, level_blue}, 32'd0);
    check("rst_pwm", {29'd0, pwm_red, pwm_green, pwm_blue}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // 2. red ramp up, hold 3 ticks
    sb.push_back('{24'h0A0000, 13, 0});
    send(24'h0A0000, 8'd3, "accept_t2");
    wait_idle("idle_t2");
    check("ready_t2", {31'd0, cmd_ready}, 32'd1);

    // 3. red down, green/blue up, independent stop points
    sb.push_back('{24'h000503, 10, 0});
    send(24'h000503, 8'd0, "accept_t3");
    wait_idle("idle_t3");

    // 4. same colour: FADE 1 cycle, HOLD 1 cycle
    sb.push_back('{24'h000503, -1, 3});
    send(24'h000503, 8'd0, "accept_t4");
    wait_idle("idle_t4");

    // 5. valid held through busy; second accept lands on done; reset mid-FADE
    sb.push_back('{24'h020202, 4, 0});
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_color = 24'h020202;
    cmd_hold  = 8'd1;
    wait_accept("accept_t5a");
    @(posedge clk); #1;
    cmd_color = 24'hFFFFFF;
    cmd_hold  = 8'd0;
    wait_accept("accept_t5b");
    check("accept_on_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_mid_fade", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_levels", {8'd0, level_red, level_green, level_blue}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (40) @(negedge clk);
    check("done_count", done_seen, 4);
    check("cmd_lost_levels", {8'd0, level_red, level_green, level_blue}, 32'd0);

    // 6. PWM duty at steady levels
    sb.push_back('{24'h40FF00, 255, 0});
    send(24'h40FF00, 8'd0, "accept_t6a");
    wait_idle("idle_t6a");
    measure(E1R, E1G, 0);
    sb.push_back('{24'h800F00, 242, 0});
    send(24'h800F00, 8'd2, "accept_t6b");
    wait_idle("idle_t6b");
    measure(E2R, E2G, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
